wb_sram_ctrl_param: RTL and testbench

Parametrised Wishbone-to-asynchronous-SRAM bridge. It is the next generation of the team's fixed 8-bit SRAM controller and merges the slave interface and SRAM sequencer into one block. It serves one 32-bit Wishbone transfer at a time and splits it into 8- or 16-bit SRAM beats. New over the previous generation: per-byte selects with lane skipping, programmable wait states, out-of-range error response, and cycle abort.

---
 rtl/wb_sram_ctrl_param_if.sv | 23 ++
 rtl/wb_sram_ctrl_param.sv | 181 ++++++++++++++++++
 tb/tb_wb_sram_ctrl_param.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_ctrl_param_if.sv
// Wishbone classic bus between a master and the SRAM bridge. Signal names
// follow the master's view, so the slave drives the *_I signals.
interface wb_sram_ctrl_param_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic        ERR_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I, ERR_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I, ERR_I
  );
endinterface

// File: rtl/wb_sram_ctrl_param.sv
// Wishbone-to-asynchronous-SRAM bridge: one 32-bit transfer at a time, split into
// 8- or 16-bit beats with byte-lane skipping, wait states, range error and abort.
module wb_sram_ctrl_param #(
  parameter int SRAM_DW     = 8,
  parameter int SRAM_AW     = 17,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  wb_sram_ctrl_param_if.slave  wb,
  output logic [SRAM_AW-1:0]   Sram_addr,
  inout  wire  [SRAM_DW-1:0]   Sram_data,
  output logic [SRAM_DW/8-1:0] Sram_ben,
  output logic                 Sram_wen,
  output logic                 Sram_oen,
  output logic                 Sram_cen
);
  localparam int LANES = 32 / SRAM_DW;
  localparam int BPL   = SRAM_DW / 8;
  localparam int BSH   = (BPL == 2) ? 1 : 0;
  localparam int LW    = (LANES == 4) ? 2 : 1;
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SETUP, S_ACCESS, S_HOLD, S_DONE
  } state_e;

  state_e             state_q;
  logic [31:0]        adr_q, wdat_q, rdat_q;
  logic [3:0]         sel_q;
  logic               we_q, err_pend_q, ack_q, err_q;
  logic [LW-1:0]      lane_q;
  logic [LANES-1:0]   pend_q;
  logic [3:0]         wcnt_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dout_q;
  logic               doe_q;
  logic [BPL-1:0]     ben_q;
  logic               wen_q, oen_q, cen_q;

  logic [LANES-1:0]   act_d, src_d, rest_d;
  logic [LW-1:0]      lane_d;
  logic               oor_d, busy_d, load_beat_d;

  function automatic logic [SRAM_AW-1:0] lane_addr(input logic [31:0] adr,
                                                   input logic [LW-1:0] lane);
    logic [31:0] w;
    w = ((adr >> BSH) & ~32'(LANES - 1)) | 32'(lane);
    return w[SRAM_AW-1:0];
  endfunction

  // Next lane comes from the select mask in CHECK and from the pending mask in HOLD.
  always_comb begin
    act_d = '0;
    for (int l = 0; l < LANES; l++) act_d[l] = |sel_q[l*BPL +: BPL];
    oor_d  = (adr_q >> (SRAM_AW + BSH)) != 32'd0;
    src_d  = (state_q == S_CHECK) ? act_d : pend_q;
    lane_d = '0;
    for (int l = LANES - 1; l >= 0; l--) if (src_d[l]) lane_d = LW'(l);
    rest_d = src_d & ~(LANES'(1) << lane_d);
    busy_d = state_q inside {S_CHECK, S_SETUP, S_ACCESS, S_HOLD};
    load_beat_d = wb.CYC_O &&
                  ((state_q == S_CHECK && !oor_d && act_d != '0) ||
                   (state_q == S_HOLD && pend_q != '0));
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      err_pend_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      lane_q     <= '0;
      pend_q     <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      doe_q      <= 1'b0;
      ben_q      <= '1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      cen_q      <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (busy_d && !wb.CYC_O) begin
        state_q <= S_IDLE;
        cen_q   <= 1'b1;
        wen_q   <= 1'b1;
        oen_q   <= 1'b1;
        ben_q   <= '1;
        doe_q   <= 1'b0;
      end else begin
        unique case (state_q)
          // The ACK/ERR cycle is not a capture cycle: the master still holds STB there.
          S_IDLE: if (wb.CYC_O && wb.STB_O && !ack_q && !err_q) begin
            adr_q      <= wb.ADR_O;
            wdat_q     <= wb.DAT_O;
            sel_q      <= wb.SEL_O;
            we_q       <= wb.WE_O;
            err_pend_q <= 1'b0;
            state_q    <= S_CHECK;
          end
          S_CHECK: begin
            if (oor_d) begin
              err_pend_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              if (!we_q) rdat_q <= '0;
              state_q <= (act_d == '0) ? S_DONE : S_SETUP;
            end
          end
          S_SETUP: begin
            wcnt_q <= '0;
            if (we_q) wen_q <= 1'b0;
            else      oen_q <= 1'b0;
            state_q <= S_ACCESS;
          end
          S_ACCESS: begin
            if (wcnt_q == WLAST) begin
              wen_q   <= 1'b1;
              oen_q   <= 1'b1;
              state_q <= S_HOLD;
              if (!we_q) begin
                for (int b = 0; b < BPL; b++)
                  if (sel_q[int'(lane_q)*BPL + b])
                    rdat_q[int'(lane_q)*SRAM_DW + 8*b +: 8] <= Sram_data[8*b +: 8];
              end
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
          S_HOLD: begin
            if (pend_q != '0) begin
              state_q <= S_SETUP;
            end else begin
              state_q <= S_DONE;
              cen_q   <= 1'b1;
              ben_q   <= '1;
              doe_q   <= 1'b0;
            end
          end
          S_DONE: begin
            ack_q   <= !err_pend_q;
            err_q   <= err_pend_q;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
        // NOTE: the last non-blocking assignment to a register wins, so this beat
        // loader deliberately overrides the case arms above on a lane change.
        if (load_beat_d) begin
          lane_q <= lane_d;
          pend_q <= rest_d;
          addr_q <= lane_addr(adr_q, lane_d);
          ben_q  <= ~sel_q[int'(lane_d)*BPL +: BPL];
          cen_q  <= 1'b0;
          if (we_q) begin
            dout_q <= wdat_q[int'(lane_d)*SRAM_DW +: SRAM_DW];
            doe_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign wb.DAT_I  = rdat_q;
  assign wb.ACK_I  = ack_q;
  assign wb.ERR_I  = err_q;
  assign Sram_addr = addr_q;
  assign Sram_ben  = ben_q;
  assign Sram_wen  = wen_q;
  assign Sram_oen  = oen_q;
  assign Sram_cen  = cen_q;
  assign Sram_data = doe_q ? dout_q : {SRAM_DW{1'bz}};
endmodule

// File: tb/tb_wb_sram_ctrl_param.sv
// Bench for the Wishbone/SRAM bridge: an 8-bit (1 wait) and a 16-bit (3 wait)
// instance, each with an attached SRAM model, checked against a byte-level memory model.
module tb_wb_sram_ctrl_param;
  localparam int W8  = 1;
  localparam int W16 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sram_ctrl_param_if wb8 ();
  wb_sram_ctrl_param_if wb16 ();

  logic [16:0] sa8, sa16;
  wire  [7:0]  sd8;
  wire  [15:0] sd16;
  logic [0:0]  sben8;
  logic [1:0]  sben16;
  logic        swen8, soen8, scen8, swen16, soen16, scen16;

  wb_sram_ctrl_param #(.SRAM_DW(8), .SRAM_AW(17), .WAIT_CYCLES(W8)) dut8 (
    .CLK_I(clk), .RST_I(rst), .wb(wb8), .Sram_addr(sa8), .Sram_data(sd8),
    .Sram_ben(sben8), .Sram_wen(swen8), .Sram_oen(soen8), .Sram_cen(scen8));

  wb_sram_ctrl_param #(.SRAM_DW(16), .SRAM_AW(17), .WAIT_CYCLES(W16)) dut16 (
    .CLK_I(clk), .RST_I(rst), .wb(wb16), .Sram_addr(sa16), .Sram_data(sd16),
    .Sram_ben(sben16), .Sram_wen(swen16), .Sram_oen(soen16), .Sram_cen(scen16));

  // SRAM models plus a probe driver used to prove the DUT has released the bus.
  logic [7:0]  mem8  [0:131071];
  logic [15:0] mem16 [0:131071];
  logic        pr8_en = 1'b0, pr16_en = 1'b0;
  logic [7:0]  pr8_val = 8'h00;
  logic [15:0] pr16_val = 16'h0000;

  assign sd8  = pr8_en  ? pr8_val  : ((!scen8  && !soen8)  ? mem8[sa8]   : 8'bz);
  assign sd16 = pr16_en ? pr16_val : ((!scen16 && !soen16) ? mem16[sa16] : 16'bz);

  always @(posedge clk) begin
    if (!scen8 && !swen8 && !sben8[0]) mem8[sa8] <= sd8;
    if (!scen16 && !swen16) begin
      if (!sben16[0]) mem16[sa16][7:0]  <= sd16[7:0];
      if (!sben16[1]) mem16[sa16][15:8] <= sd16[15:8];
    end
  end

  // Strobe monitor: cycle counts and protocol violations per instance.
  int          cen_cnt [2];
  int          wen_cnt [2];
  int          viol    [2];
  logic [16:0] pa8, pa16;
  always @(negedge clk) begin
    if (!scen8)  cen_cnt[0] += 1;
    if (!swen8)  wen_cnt[0] += 1;
    if (!scen16) cen_cnt[1] += 1;
    if (!swen16) wen_cnt[1] += 1;
    if (!swen8  && (sa8  != pa8  || scen8  || !soen8))  viol[0] += 1;
    if (!swen16 && (sa16 != pa16 || scen16 || !soen16)) viol[1] += 1;
    pa8  <= sa8;
    pa16 <= sa16;
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  refm [int];
  logic [31:0] last_rd [2];

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_get(input int d, input logic [31:0] a);
    int key;
    key = (d << 20) + int'(a[19:0]);
    return refm.exists(key) ? refm[key] : 8'h00;
  endfunction

  function automatic void ref_put(input int d, input logic [31:0] a, input logic [7:0] v);
    refm[(d << 20) + int'(a[19:0])] = v;
  endfunction

  function automatic bit model_oor(input int d, input logic [31:0] adr);
    return (d == 0) ? ((adr >> 17) != 0) : ((adr >> 18) != 0);
  endfunction

  function automatic int model_lat(input int d, input logic [31:0] adr, input logic [3:0] sel);
    int n;
    if (model_oor(d, adr)) return 2;
    n = (d == 0) ? $countones(sel) : (int'(sel[1:0] != 0) + int'(sel[3:2] != 0));
    if (n == 0) return 2;
    return 2 + n * (((d == 0) ? W8 : W16) + 2);
  endfunction

  // ---------------- bus driving ----------------
  task automatic drive(input int d, input logic [31:0] adr, dat, input logic [3:0] sel,
                       input logic we, cs);
    if (d == 0) begin
      wb8.ADR_O = adr; wb8.DAT_O = dat; wb8.SEL_O = sel; wb8.WE_O = we;
      wb8.CYC_O = cs;  wb8.STB_O = cs;
    end else begin
      wb16.ADR_O = adr; wb16.DAT_O = dat; wb16.SEL_O = sel; wb16.WE_O = we;
      wb16.CYC_O = cs;  wb16.STB_O = cs;
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? wb8.ACK_I : wb16.ACK_I;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? wb8.ERR_I : wb16.ERR_I;
  endfunction
  function automatic logic [31:0] get_dat(input int d);
    return (d == 0) ? wb8.DAT_I : wb16.DAT_I;
  endfunction

  // Edge 0 is the first rising edge after the request is presented.
  task automatic xfer(input int d, input logic [31:0] adr, dat, input logic [3:0] sel,
                      input logic we, output int lat, output logic ack, err,
                      output logic [31:0] rd);
    @(negedge clk);
    drive(d, adr, dat, sel, we, 1'b1);
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (get_ack(d) || get_err(d)) begin
        lat = k; ack = get_ack(d); err = get_err(d); rd = get_dat(d);
        break;
      end
    end
    @(negedge clk);
    drive(d, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_xfer(input int d, input logic [31:0] adr, dat, input logic [3:0] sel,
                         input logic we, input string tag);
    int          lat, exp_lat;
    logic        ack, err, exp_err;
    logic [31:0] rd, exp_rd, base;
    exp_err = model_oor(d, adr);
    exp_lat = model_lat(d, adr, sel);
    base    = adr & ~32'h3;
    exp_rd  = last_rd[d];
    if (!exp_err && !we) begin
      for (int i = 0; i < 4; i++)
        exp_rd[8*i +: 8] = sel[i] ? ref_get(d, base + 32'(i)) : 8'h00;
    end
    xfer(d, adr, dat, sel, we, lat, ack, err, rd);
    n_total++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    else n_pass++;
    n_total++;
    if ({ack, err} !== {!exp_err, exp_err})
      $display("FAIL %s ack/err: got %b%b want %b%b", tag, ack, err, !exp_err, exp_err);
    else n_pass++;
    n_total++;
    if (rd !== exp_rd) $display("FAIL %s DAT_I: got %h want %h", tag, rd, exp_rd);
    else n_pass++;
    if (!exp_err && we) begin
      for (int i = 0; i < 4; i++) if (sel[i]) ref_put(d, base + 32'(i), dat[8*i +: 8]);
    end
    last_rd[d] = exp_rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(0, '0, '0, '0, 1'b0, 1'b0);
    drive(1, '0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    pr8_en = 1'b1; pr8_val = 8'h5A; pr16_en = 1'b1; pr16_val = 16'hA55A;
    #1;
    n_total++;
    if ({wb8.ACK_I, wb8.ERR_I, wb8.DAT_I, sa8, scen8, swen8, soen8, sben8} !==
        {2'b00, 32'h0, 17'h0, 3'b111, 1'b1})
      $display("FAIL reset8 outputs: got %b %h %h %b%b%b %b", {wb8.ACK_I, wb8.ERR_I},
               wb8.DAT_I, sa8, scen8, swen8, soen8, sben8);
    else n_pass++;
    n_total++;
    if ({wb16.ACK_I, wb16.ERR_I, wb16.DAT_I, sa16, scen16, swen16, soen16, sben16} !==
        {2'b00, 32'h0, 17'h0, 3'b111, 2'b11})
      $display("FAIL reset16 outputs: got %b %h %h %b%b%b %b", {wb16.ACK_I, wb16.ERR_I},
               wb16.DAT_I, sa16, scen16, swen16, soen16, sben16);
    else n_pass++;
    n_total++;
    if ({sd8, sd16} !== {8'h5A, 16'hA55A})
      $display("FAIL reset bus release: got %h %h want 5a a55a", sd8, sd16);
    else n_pass++;
    pr8_en = 1'b0; pr16_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed8();
    int c0;
    do_xfer(0, 32'h100, 32'hA1B2C3D4, 4'hF, 1'b1, "full_write");
    n_total++;
    if ({mem8[32'h103], mem8[32'h102], mem8[32'h101], mem8[32'h100]} !== 32'hA1B2C3D4)
      $display("FAIL full_write sram: got %h want a1b2c3d4",
               {mem8[32'h103], mem8[32'h102], mem8[32'h101], mem8[32'h100]});
    else n_pass++;
    do_xfer(0, 32'h100, 32'h0, 4'hF, 1'b0, "full_read");
    do_xfer(0, 32'h200, 32'h11223344, 4'hF, 1'b1, "pre_write");
    do_xfer(0, 32'h200, 32'h00EE0000, 4'h4, 1'b1, "partial_write");
    n_total++;
    if ({mem8[32'h203], mem8[32'h202], mem8[32'h201], mem8[32'h200]} !== 32'h11EE3344)
      $display("FAIL partial_write sram: got %h want 11ee3344",
               {mem8[32'h203], mem8[32'h202], mem8[32'h201], mem8[32'h200]});
    else n_pass++;
    do_xfer(0, 32'h201, 32'h0, 4'h6, 1'b0, "partial_read");
    c0 = cen_cnt[0];
    do_xfer(0, 32'h0002_0000, 32'hDEADBEEF, 4'hF, 1'b1, "range_err");
    do_xfer(0, 32'h100, 32'h0, 4'h0, 1'b0, "sel0_read");
    n_total++;
    if (cen_cnt[0] - c0 !== 0)
      $display("FAIL err_sel0 no_strobe: got %0d cen cycles want 0", cen_cnt[0] - c0);
    else n_pass++;
  endtask

  task automatic test_dw16();
    int w0;
    w0 = wen_cnt[1];
    do_xfer(1, 32'h10, 32'h12345678, 4'hF, 1'b1, "dw16_write");
    n_total++;
    if (wen_cnt[1] - w0 !== 2 * W16)
      $display("FAIL dw16 wen cycles: got %0d want %0d", wen_cnt[1] - w0, 2 * W16);
    else n_pass++;
    n_total++;
    if ({mem16[9], mem16[8]} !== 32'h12345678)
      $display("FAIL dw16 sram: got %h want 12345678", {mem16[9], mem16[8]});
    else n_pass++;
    do_xfer(1, 32'h10, 32'h0000AB00, 4'h2, 1'b1, "dw16_byte_write");
    n_total++;
    if (mem16[8] !== 16'hAB78) $display("FAIL dw16 byte lane: got %h want ab78", mem16[8]);
    else n_pass++;
    do_xfer(1, 32'h12, 32'h0, 4'hB, 1'b0, "dw16_read");
    do_xfer(1, 32'h0004_0000, 32'h0, 4'hF, 1'b0, "dw16_range_err");
  endtask

  task automatic test_random();
    logic [31:0] adr;
    for (int i = 0; i < 120; i++) begin
      int d;
      d = i % 2;
      if ($urandom_range(0, 7) == 0)
        adr = $urandom | (32'h1 << ((d == 0) ? 17 : 18));
      else
        adr = 32'h1000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
      do_xfer(d, adr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_abort();
    logic seen;
    do_xfer(0, 32'h300, 32'h44332211, 4'hF, 1'b1, "abort_pre");
    @(negedge clk);
    drive(0, 32'h300, 32'h8877A566, 4'hF, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if ({sa8, swen8} !== {17'h301, 1'b0})
      $display("FAIL abort lane1 access: got addr %h wen %b want 301 0", sa8, swen8);
    else n_pass++;
    drive(0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    pr8_en = 1'b1; pr8_val = 8'h5A;
    #1;
    n_total++;
    if ({scen8, swen8, soen8, sben8, sd8, wb8.ACK_I, wb8.ERR_I} !== {4'b1111, 8'h5A, 2'b00})
      $display("FAIL abort release: got %b%b%b%b bus %h ack/err %b%b", scen8, swen8, soen8,
               sben8, sd8, wb8.ACK_I, wb8.ERR_I);
    else n_pass++;
    pr8_en = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | wb8.ACK_I | wb8.ERR_I;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL abort no_ack: got ack/err %b want 0", seen);
    else n_pass++;
    ref_put(0, 32'h300, 8'h66);
    do_xfer(0, 32'h300, 32'h0, 4'hD, 1'b0, "abort_readback");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (swen16 !== 1'b0) $display("FAIL reset_mid in_access: got wen %b want 0", swen16);
    else n_pass++;
    rst = 1'b1;
    drive(1, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    pr16_en = 1'b1; pr16_val = 16'hA55A;
    #1;
    n_total++;
    if ({wb16.ACK_I, wb16.ERR_I, wb16.DAT_I, sa16, scen16, swen16, soen16, sben16, sd16} !==
        {2'b00, 32'h0, 17'h0, 3'b111, 2'b11, 16'hA55A})
      $display("FAIL reset_mid outputs: got %b%b %h %h %b%b%b %b bus %h", wb16.ACK_I,
               wb16.ERR_I, wb16.DAT_I, sa16, scen16, swen16, soen16, sben16, sd16);
    else n_pass++;
    n_total++;
    if (wb8.DAT_I !== 32'h0) $display("FAIL reset_mid dat8: got %h want 0", wb8.DAT_I);
    else n_pass++;
    pr16_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    do_xfer(1, 32'h1010, 32'h0, 4'hF, 1'b0, "post_reset_read");
  endtask

  task automatic test_protocol();
    n_total++;
    if (viol[0] !== 0) $display("FAIL protocol8: got %0d violations want 0", viol[0]);
    else n_pass++;
    n_total++;
    if (viol[1] !== 0) $display("FAIL protocol16: got %0d violations want 0", viol[1]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) begin
      mem8[i]  <= 8'h00;
      mem16[i] <= 16'h0000;
    end
    cen_cnt = '{0, 0};
    wen_cnt = '{0, 0};
    viol    = '{0, 0};
    last_rd = '{32'h0, 32'h0};
    test_reset();
    test_directed8();
    test_dw16();
    test_random();
    test_abort();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
